// File: rtl/game_meteor_pkg.sv
// Shared types and constants for the meteor spawner and its LFSR.
package game_meteor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        LOAD = 2'd2,
        FLY  = 2'd3
    } meteor_state_t;

    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam int          SPEEDUP_PERIOD = 8;

endpackage

// File: rtl/game_lfsr16.sv
// 16-bit right-shifting Galois LFSR; free-runs whenever enabled and out of reset.
module game_lfsr16
    import game_meteor_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (!rst)
            state <= SEED;
        else if (en)
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
    end

endmodule

// File: rtl/game_meteor_spawner.sv
// Spawn/respawn controller for one meteor sprite: random X, dx and delay from an LFSR.
// Optional GAME_METEOR_SPEEDUP_EN: dy steps up every 8th spawn, saturating.
module game_meteor_spawner
    import game_meteor_pkg::*;
#(
    parameter int          screen_width    = 640,
    parameter int          screen_height   = 480,
    parameter int          w_x             = $clog2(screen_width),
    parameter int          w_y             = $clog2(screen_height),
    parameter int          SPRITE_WIDTH    = 16,
    parameter int          DX_WIDTH        = 2,
    parameter int          DY_WIDTH        = 2,
    parameter int          DY_INIT         = 1,
    parameter int          SPAWN_DELAY_MIN = 1000,
    parameter int          RANDOM_DELAY_W  = 8,
    parameter int          GRACE_CYCLES    = 4,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                game_active,
    input  logic                hit,
    input  logic                sprite_within_screen,
    output logic                sprite_write_xy,
    output logic                sprite_write_dxy,
    output logic [w_x-1:0]      sprite_write_x,
    output logic [w_y-1:0]      sprite_write_y,
    output logic [DX_WIDTH-1:0] sprite_write_dx,
    output logic [DY_WIDTH-1:0] sprite_write_dy,
    output logic                sprite_enable_update,
    output logic [7:0]          spawn_count
);

    localparam int X_MAX   = screen_width - SPRITE_WIDTH;
    localparam int DLY_MAX = SPAWN_DELAY_MIN + (1 << RANDOM_DELAY_W) - 1;
    localparam int CNT_W   = (DLY_MAX > 0) ? $clog2(DLY_MAX + 1) : 1;
    localparam int G_W     = (GRACE_CYCLES > 0) ? $clog2(GRACE_CYCLES + 1) : 1;

    localparam logic [DY_WIDTH-1:0] DY_DEF = DY_WIDTH'(DY_INIT);
    localparam logic [G_W-1:0]      G_INIT = G_W'(GRACE_CYCLES);

    meteor_state_t      state;
    logic [15:0]        lfsr;
    logic [CNT_W-1:0]   dly_cnt;
    logic [CNT_W-1:0]   delay;
    logic [G_W-1:0]     grace;
    logic [w_x-1:0]     x_raw;
    logic [w_x-1:0]     x_next;
    logic [DX_WIDTH-1:0] dx_next;
    logic [DY_WIDTH-1:0] dy_load;
    logic [7:0]         count_next;
    logic               lfsr_unused;

    game_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .state (lfsr)
    );

    // Not every LFSR bit feeds a spawn field.
    assign lfsr_unused = ^lfsr;

    generate
        if (RANDOM_DELAY_W > 0) begin : g_rand_delay
            assign delay = CNT_W'(SPAWN_DELAY_MIN) + CNT_W'(lfsr[RANDOM_DELAY_W-1:0]);
        end else begin : g_fixed_delay
            assign delay = CNT_W'(SPAWN_DELAY_MIN);
        end
    endgenerate

    // One conditional subtract folds the raw value into range since 2^w_x < 2*X_MAX.
    assign x_raw      = lfsr[w_x-1:0];
    assign x_next     = (int'(x_raw) >= X_MAX) ? x_raw - w_x'(X_MAX) : x_raw;
    assign dx_next    = lfsr[15:16-DX_WIDTH];
    assign count_next = spawn_count + 8'd1;

`ifdef GAME_METEOR_SPEEDUP_EN
    localparam logic [DY_WIDTH-1:0] DY_MAX = '1;
    assign dy_load = ((int'(count_next) % SPEEDUP_PERIOD) == 0 && sprite_write_dy != DY_MAX)
                   ? sprite_write_dy + 1'b1 : sprite_write_dy;
`else
    assign dy_load = DY_DEF;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state                <= IDLE;
            sprite_write_xy      <= 1'b0;
            sprite_write_dxy     <= 1'b0;
            sprite_write_x       <= '0;
            sprite_write_y       <= '0;
            sprite_write_dx      <= '0;
            sprite_write_dy      <= DY_DEF;
            sprite_enable_update <= 1'b0;
            spawn_count          <= 8'd0;
            dly_cnt              <= '0;
            grace                <= '0;
        end else if (!game_active) begin
            state                <= IDLE;
            sprite_write_xy      <= 1'b0;
            sprite_write_dxy     <= 1'b0;
            sprite_enable_update <= 1'b0;
            sprite_write_dy      <= DY_DEF;
        end else begin
            sprite_write_xy  <= 1'b0;
            sprite_write_dxy <= 1'b0;
            case (state)
                IDLE: begin
                    state   <= WAIT;
                    dly_cnt <= delay;
                end
                WAIT: begin
                    if (dly_cnt == '0) begin
                        state            <= LOAD;
                        sprite_write_xy  <= 1'b1;
                        sprite_write_dxy <= 1'b1;
                        sprite_write_x   <= x_next;
                        sprite_write_y   <= '0;
                        sprite_write_dx  <= dx_next;
                        sprite_write_dy  <= dy_load;
                        spawn_count      <= count_next;
                    end else begin
                        dly_cnt <= dly_cnt - 1'b1;
                    end
                end
                LOAD: begin
                    state                <= FLY;
                    sprite_enable_update <= 1'b1;
                    grace                <= G_INIT;
                end
                FLY: begin
                    if (grace != '0)
                        grace <= grace - 1'b1;
                    // A hit coinciding with a screen exit is a single respawn event.
                    if (hit || (grace == '0 && !sprite_within_screen)) begin
                        state                <= WAIT;
                        sprite_enable_update <= 1'b0;
                        dly_cnt              <= delay;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_meteor_spawner.sv
// Directed bench for game_meteor_spawner with a fixed 10-cycle spawn delay.
module tb_game_meteor_spawner;

    logic       clk;
    logic       rst;
    logic       game_active;
    logic       hit;
    logic       sprite_within_screen;
    logic       sprite_write_xy;
    logic       sprite_write_dxy;
    logic [9:0] sprite_write_x;
    logic [8:0] sprite_write_y;
    logic [1:0] sprite_write_dx;
    logic [1:0] sprite_write_dy;
    logic       sprite_enable_update;
    logic [7:0] spawn_count;

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    int dy_m = 1;
    logic [15:0] m_lfsr;
    logic [15:0] m_prev;

    game_meteor_spawner #(
        .SPAWN_DELAY_MIN (10),
        .RANDOM_DELAY_W  (0)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .game_active          (game_active),
        .hit                  (hit),
        .sprite_within_screen (sprite_within_screen),
        .sprite_write_xy      (sprite_write_xy),
        .sprite_write_dxy     (sprite_write_dxy),
        .sprite_write_x       (sprite_write_x),
        .sprite_write_y       (sprite_write_y),
        .sprite_write_dx      (sprite_write_dx),
        .sprite_write_dy      (sprite_write_dy),
        .sprite_enable_update (sprite_enable_update),
        .spawn_count          (spawn_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    // Reference LFSR; m_prev holds the value seen before the latest edge.
    always @(posedge clk) begin
        if (!rst) begin
            m_lfsr <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic wait_load(output int n);
        n = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (sprite_write_xy) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk("load_timeout", 0, 1);
    endtask

    task automatic check_load();
        logic [9:0] xr;
        exp_cnt++;
`ifdef GAME_METEOR_SPEEDUP_EN
        if ((exp_cnt % 8) == 0 && dy_m < 3) dy_m++;
`endif
        xr = m_prev[9:0];
        if (xr >= 10'd624) xr = xr - 10'd624;
        chk("load_dxy", sprite_write_dxy, 1);
        chk("load_x", sprite_write_x, xr);
        chk("load_x_range", sprite_write_x < 10'd624, 1);
        chk("load_y", sprite_write_y, 0);
        chk("load_dx", sprite_write_dx, m_prev[15:14]);
        chk("load_dy", sprite_write_dy, dy_m);
        chk("load_count", spawn_count, exp_cnt[7:0]);
    endtask

    task automatic quiet_window(input string tag);
        int strobes;
        int moving;
        strobes = 0;
        moving = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            strobes += int'(sprite_write_xy | sprite_write_dxy);
            moving += int'(sprite_enable_update);
        end
        chk({tag, "_strobe"}, strobes, 0);
        chk({tag, "_en"}, moving, 0);
    endtask

    initial begin
        int n;
        int en_hi;
        rst = 1'b0;
        game_active = 1'b0;
        hit = 1'b0;
        sprite_within_screen = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_xy", sprite_write_xy, 0);
        chk("rst_dxy", sprite_write_dxy, 0);
        chk("rst_x", sprite_write_x, 0);
        chk("rst_y", sprite_write_y, 0);
        chk("rst_dx", sprite_write_dx, 0);
        chk("rst_dy", sprite_write_dy, 1);
        chk("rst_en", sprite_enable_update, 0);
        chk("rst_count", spawn_count, 0);
        rst = 1'b1;
        chk("lfsr_seed", dut.lfsr, 16'hACE1);

        // First spawn: 1 edge to WAIT, 11 in WAIT -> strobes 12 edges after raise.
        game_active = 1'b1;
        wait_load(n);
        chk("first_lat", n, 12);
        check_load();

        // Exit during grace is ignored; after grace the meteor leaves.
        sprite_within_screen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("single_xy", sprite_write_xy, 0);
        chk("single_dxy", sprite_write_dxy, 0);
        en_hi = int'(sprite_enable_update);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            en_hi += int'(sprite_enable_update);
        end
        chk("grace_en", en_hi, 5);
        @(posedge clk);
        @(negedge clk);
        chk("exit_en", sprite_enable_update, 0);
        wait_load(n);
        chk("respawn_lat", n, 11);
        sprite_within_screen = 1'b1;
        check_load();

        // Hit together with exit: one return to WAIT.
        repeat (6) begin
            @(posedge clk);
            @(negedge clk);
        end
        hit = 1'b1;
        sprite_within_screen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        hit = 1'b0;
        sprite_within_screen = 1'b1;
        chk("hitexit_en", sprite_enable_update, 0);
        wait_load(n);
        chk("hitexit_lat", n, 11);
        check_load();

        // Hit during grace, then abort while in WAIT.
        @(posedge clk);
        @(negedge clk);
        hit = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hit = 1'b0;
        chk("hit_grace_en", sprite_enable_update, 0);
        game_active = 1'b0;
        dy_m = 1;
        quiet_window("abort_wait");
        chk("abort_wait_count", spawn_count, 3);

        // Abort while flying.
        game_active = 1'b1;
        wait_load(n);
        chk("restart_lat", n, 12);
        check_load();
        @(posedge clk);
        @(negedge clk);
        chk("fly_en", sprite_enable_update, 1);
        game_active = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_fly_en", sprite_enable_update, 0);
        dy_m = 1;
        quiet_window("abort_fly");

        // Long run of spawns up to 40 to cover dy stepping and saturation.
        game_active = 1'b1;
        for (int c = 5; c <= 40; c++) begin
            wait_load(n);
            chk("run_lat", n, (c == 5) ? 12 : 11);
            check_load();
            @(posedge clk);
            @(negedge clk);
            hit = 1'b1;
            @(posedge clk);
            @(negedge clk);
            hit = 1'b0;
        end

        // dy returns to its initial value after passing through IDLE.
        game_active = 1'b0;
        dy_m = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("idle_dy", sprite_write_dy, 1);
        game_active = 1'b1;
        wait_load(n);
        check_load();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
